// File: rtl/gpr_wb_arbiter_pkg.sv
// gpr_wb_pkg -- shared constants for the GPR write-back arbiter slice.
//   NREQ_DEF / AW_DEF / DW_DEF : default requester count, register address
//                                width and register data width.
//   REQ_ALU / REQ_MEM / REQ_MDU: requester index assignment (lower index has
//                                higher fixed priority).
//   ptrWidth()                 : width of an index into NREQ requesters
//                                (never less than one bit).
package gpr_wb_pkg;

   localparam int NREQ_DEF = 3;
   localparam int AW_DEF   = 5;
   localparam int DW_DEF   = 32;

   localparam int REQ_ALU  = 0;
   localparam int REQ_MEM  = 1;
   localparam int REQ_MDU  = 2;

   function automatic int ptrWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// gpr_wb_arbiter_if -- bundle of every signal exchanged between the write-back
// arbiter and its surroundings (requesters, issue stage, hazard query, GPR
// write port).
//   req_valid/req_addr/req_data : per-requester write request (packed, req 0 in
//                                 the low slice), req_ready is the one-hot grant.
//   issue_valid/issue_reg       : destination register marked pending at issue.
//   flush                       : discard all pending state.
//   chk_reg1/chk_reg2, hazard   : source-register hazard query.
//   RegWrite/WriteRegister/WriteData : registered GPR write port.
// Modports: master = requesters/issue/GPR side, slave = the arbiter.
interface gpr_wb_arbiter_if
   import gpr_wb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int AW   = AW_DEF,
   parameter int DW   = DW_DEF
) ();

   logic [NREQ-1:0]    req_valid;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               issue_valid;
   logic [AW-1:0]      issue_reg;
   logic               flush;
   logic [AW-1:0]      chk_reg1;
   logic [AW-1:0]      chk_reg2;
   logic               hazard;
   logic               RegWrite;
   logic [AW-1:0]      WriteRegister;
   logic [DW-1:0]      WriteData;

   modport master (
      output req_valid, req_addr, req_data,
      output issue_valid, issue_reg, flush, chk_reg1, chk_reg2,
      input  req_ready, hazard, RegWrite, WriteRegister, WriteData
   );

   modport slave (
      input  req_valid, req_addr, req_data,
      input  issue_valid, issue_reg, flush, chk_reg1, chk_reg2,
      output req_ready, hazard, RegWrite, WriteRegister, WriteData
   );

endinterface

// File: rtl/gpr_wb_arbiter_rr.sv
// wb_rr_arbiter -- grant selection for the write-back requesters.
// Configuration macro: GPR_WB_RR_ARB_EN
//   defined   : round-robin; the search starts one past the last granted
//               index, and the pointer only moves when a grant is given
//               (a grant always means acceptance, since it requires valid).
//   undefined : fixed priority, lowest index wins; no state, no clock port.
// Ports:
//   clk      : clock (round-robin build only)
//   rst      : synchronous active-high reset; forces grant to zero and
//              returns the pointer to NREQ-1 so requester 0 goes first
//   flush    : forces grant to zero
//   reqValid : per-requester request
//   grant    : one-hot grant (zero when nothing is granted)
module wb_rr_arbiter
   import gpr_wb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF
) (
`ifdef GPR_WB_RR_ARB_EN
   input  logic            clk,
`endif
   input  logic            rst,
   input  logic            flush,
   input  logic [NREQ-1:0] reqValid,
   output logic [NREQ-1:0] grant
);

   localparam int PW = ptrWidth(NREQ);

   logic          found;
   logic [PW-1:0] cand;

`ifdef GPR_WB_RR_ARB_EN

   logic [PW-1:0] ptr;
   logic [PW-1:0] grantIdx;

   always_comb begin
      grant    = '0;
      grantIdx = '0;
      found    = 1'b0;
      cand     = '0;
      if (!rst && !flush) begin
         // Walk NREQ candidates starting just after the last winner.
         for (int k = 1; k <= NREQ; k++) begin
            cand = PW'((int'(ptr) + k) % NREQ);
            if (!found && reqValid[cand]) begin
               grant[cand] = 1'b1;
               grantIdx    = cand;
               found       = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= PW'(NREQ - 1);
      end else if (|grant) begin
         ptr <= grantIdx;
      end
   end

`else

   always_comb begin
      grant = '0;
      found = 1'b0;
      cand  = '0;
      if (!rst && !flush) begin
         for (int k = 0; k < NREQ; k++) begin
            cand = PW'(k);
            if (!found && reqValid[cand]) begin
               grant[cand] = 1'b1;
               found       = 1'b1;
            end
         end
      end
   end

`endif

endmodule

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter -- arbitrates NREQ write-back requesters onto a single GPR
// write port and keeps a busy scoreboard of registers with writes in flight.
// Configuration macro: GPR_WB_RR_ARB_EN (round-robin instead of fixed
// priority; handled inside wb_rr_arbiter).
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset
//   bus : gpr_wb_arbiter_if.slave -- requests/grant, issue marking, flush,
//         hazard query and the registered RegWrite/WriteRegister/WriteData.
// Behaviour notes:
//   - A grant in cycle N shows on the write port in cycle N+1 for one cycle.
//   - A write to register 0 is accepted but never raises RegWrite.
//   - The busy bit of the written register clears when RegWrite is seen;
//     an issue to the same register in that cycle wins.
module gpr_wb_arbiter
   import gpr_wb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int AW   = AW_DEF,
   parameter int DW   = DW_DEF
) (
   input  logic clk,
   input  logic rst,
   gpr_wb_arbiter_if.slave bus
);

   localparam int NREG = 2 ** AW;

   logic [NREQ-1:0] grant;
   logic            accept;
   logic [AW-1:0]   selAddr;
   logic [DW-1:0]   selData;

   logic            regWrite;
   logic [AW-1:0]   writeReg;
   logic [DW-1:0]   writeData;

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busyNext;

   wb_rr_arbiter #(
      .NREQ     (NREQ)
   ) uArb (
`ifdef GPR_WB_RR_ARB_EN
      .clk      (clk),
`endif
      .rst      (rst),
      .flush    (bus.flush),
      .reqValid (bus.req_valid),
      .grant    (grant)
   );

   assign bus.req_ready = grant;
   assign accept        = |grant;

   // One-hot mux of the granted requester's address and data.
   always_comb begin
      selAddr = '0;
      selData = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            selAddr = bus.req_addr[i*AW +: AW];
            selData = bus.req_data[i*DW +: DW];
         end
      end
   end

   // Write-port stage: flush reaches here as "no grant", so RegWrite drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         regWrite  <= 1'b0;
         writeReg  <= '0;
         writeData <= '0;
      end else if (accept) begin
         regWrite  <= (selAddr != '0);
         writeReg  <= selAddr;
         writeData <= selData;
      end else begin
         regWrite  <= 1'b0;
      end
   end

   assign bus.RegWrite      = regWrite;
   assign bus.WriteRegister = writeReg;
   assign bus.WriteData     = writeData;

   // Scoreboard: clear first, then set, so a same-cycle set wins.
   always_comb begin
      busyNext = busy;
      if (regWrite) begin
         busyNext[writeReg] = 1'b0;
      end
      if (bus.issue_valid) begin
         busyNext[bus.issue_reg] = 1'b1;
      end
      busyNext[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         busy <= '0;
      end else begin
         busy <= busyNext;
      end
   end

   assign bus.hazard = busy[bus.chk_reg1] | busy[bus.chk_reg2];

endmodule

// File: doc/gpr_wb_arbiter.md
GPR_WB_ARBITER -- requirements
Module: gpr_wb_arbiter

Interface
REQ-001 Parameter NREQ, default 3, SHALL be the number of write-back requesters.
REQ-002 Parameter AW, default 5, SHALL be the register address width.
REQ-003 Parameter DW, default 32, SHALL be the register data width.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 req_valid  input  NREQ  SHALL carry the per-requester write request.
REQ-007 req_addr  input  NREQ*AW  SHALL carry the per-requester destination register.
REQ-008 req_data  input  NREQ*DW  SHALL carry the per-requester write data.
REQ-009 req_ready  output  NREQ  SHALL be a one-hot grant; a request is accepted when valid&ready.
REQ-010 issue_valid, issue_reg  input  1, AW  SHALL mark a destination register as pending at issue.
REQ-011 flush  input  1  SHALL synchronously discard all pending state.
REQ-012 chk_reg1, chk_reg2  input  AW each  SHALL be the source registers for the hazard query.
REQ-013 hazard  output  1  SHALL assert combinationally when busy[chk_reg1] or busy[chk_reg2] is set.
REQ-014 RegWrite, WriteRegister, WriteData  output  1, AW, DW  SHALL drive the GPR write port and be registered.

Function
REQ-015 The block SHALL grant at most one requester per cycle; req_ready SHALL depend only on req_valid, the arbitration state, flush and rst.
REQ-016 A request accepted in cycle N SHALL produce RegWrite=1 with its addr/data in cycle N+1, for exactly one cycle.
REQ-017 With no accepted request in cycle N, RegWrite SHALL be 0 in cycle N+1; WriteRegister/WriteData SHALL hold their previous values.
REQ-018 An accepted request to register 0 SHALL complete its handshake but SHALL drive RegWrite=0.
REQ-019 A requester held off SHALL keep valid, addr and data stable until it is granted.
REQ-020 Scoreboard: busy[issue_reg] SHALL set at the edge ending a cycle with issue_valid=1; busy[0] SHALL always read 0.
REQ-021 busy[WriteRegister] SHALL clear at the edge ending a cycle with RegWrite=1.
REQ-022 When a set and a clear hit the same register in one cycle, the set SHALL win.
REQ-023 flush=1 SHALL clear all busy bits, force req_ready=0, and force RegWrite=0 in the next cycle; issue_valid SHALL be ignored that cycle.

Reset
REQ-024 While rst=1, req_ready SHALL be 0 and all busy bits SHALL clear at the edge.
REQ-025 While rst=1, RegWrite, WriteRegister and WriteData SHALL clear to 0 at the edge.
REQ-026 While rst=1, the arbitration pointer SHALL reset to NREQ-1, so requester 0 has first priority.
REQ-027 rst SHALL discard any write accepted in the previous cycle; rst SHALL take priority over flush.

Configuration
REQ-028 With GPR_WB_RR_ARB_EN defined, arbitration SHALL be round-robin: search starts at pointer+1 modulo NREQ, and the pointer SHALL update to the granted index only on acceptance.
REQ-029 Without GPR_WB_RR_ARB_EN, arbitration SHALL be fixed priority, lowest index wins, and no pointer register SHALL exist.

Structure
REQ-030 Package gpr_wb_pkg SHALL hold NREQ/AW/DW defaults and index constants REQ_ALU=0, REQ_MEM=1, REQ_MDU=2.
REQ-031 Grant selection SHALL live in one sub-module, wb_rr_arbiter, which contains the pointer and honours the macro.

Verification
REQ-032 Reset, then req_valid=3'b001, addr=5, data=0xDEADBEEF -> ready=001 in the same cycle; next cycle RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF.
REQ-033 With the RR macro, all three requesters held valid for 6 cycles -> grants 0,1,2,0,1,2; without the macro -> grant 0 every cycle.
REQ-034 Issue reg 7, then chk_reg1=7 -> hazard=1 until the cycle after the write to reg 7 appears on RegWrite; then hazard=0.
REQ-035 Issue reg 9 in the same cycle RegWrite targets reg 9 -> busy[9] remains 1; a request to reg 0 -> ready=1 and RegWrite stays 0.
REQ-036 Accept a write, then assert rst (or flush) the next cycle -> RegWrite=0 and all busy bits clear; with rst alone, the pointer returns to NREQ-1.
